// File: rtl/fpga_arith_runner.sv
// fpga_arith_runner: executes a stream of MOV/ADD/SUB/OUT/CHECK/HALT
// instructions against a small local memory, buffers OUT results in a FIFO
// and reports finished/success/timeout for the program run.
module fpga_arith_runner #(
  parameter  int MemoryElementWidth = 12,
  parameter  int NLocal             = 8,
  parameter  int NOut               = 4,
  parameter  int MaxSteps           = 1024,
  localparam int W                  = MemoryElementWidth,
  localparam int LW                 = (NLocal > 1) ? $clog2(NLocal) : 1,
  localparam int PW                 = (NOut > 1) ? $clog2(NOut) : 1,
  localparam int CW                 = $clog2(NOut + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          run,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [LW-1:0] in_target,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  input  logic          in_a_local,
  input  logic          in_b_local,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [31:0]   steps,
  output logic          finished,
  output logic          success,
  output logic          timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_EXEC,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_MOV   = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_SUB   = 3'd2;
  localparam logic [2:0] OP_OUT   = 3'd3;
  localparam logic [2:0] OP_CHECK = 3'd4;
  localparam logic [2:0] OP_HALT  = 3'd5;

  state_e          state_q, state_d;
  logic [LW-1:0]   clr_idx_q, clr_idx_d;
  logic [31:0]     steps_q, steps_d;
  logic            finished_q, finished_d;
  logic            success_q, success_d;
  logic            timeout_q, timeout_d;
  logic            fail_q, fail_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  // Local memory is sized to the full index space so any in_target/in_a
  // index is addressable; CLEAR only zeroes the NLocal words in use.
  logic [W-1:0]    mem_q  [2**LW];
  logic [W-1:0]    fifo_q [NOut];

  logic [W-1:0]    op_a, op_b;
  logic            accept, push, pop, last_step;
  logic            mem_we;
  logic [LW-1:0]   mem_waddr;
  logic [W-1:0]    mem_wdata;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NOut - 1)) ? '0 : p + PW'(1);
  endfunction

  // Operand fetch is combinational, so a word written on one edge is seen
  // by the instruction accepted in the very next cycle.
  assign op_a      = in_a_local ? mem_q[in_a[LW-1:0]] : in_a;
  assign op_b      = in_b_local ? mem_q[in_b[LW-1:0]] : in_b;

  assign in_ready  = (state_q == S_EXEC) && (count_q != CW'(NOut));
  assign accept    = in_valid && in_ready;
  assign push      = accept && (in_op == OP_OUT);
  assign pop       = (count_q != '0) && out_ready;
  assign last_step = (steps_q + 32'd1) == 32'(MaxSteps);

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
  assign out_count = count_q;
  assign steps     = steps_q;
  assign finished  = finished_q;
  assign success   = success_q;
  assign timeout   = timeout_q;

  // Next-state, status and memory write-port decode for all states.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and infers a latch.
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    steps_d    = steps_q;
    finished_d = finished_q;
    success_d  = success_q;
    timeout_d  = timeout_q;
    fail_d     = fail_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    mem_we     = 1'b0;
    mem_waddr  = in_target;
    mem_wdata  = op_a;

    // The FIFO drains in every state; push is only possible in EXEC.
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (run) begin
          // A new run discards any unread output words.
          state_d    = S_CLEAR;
          clr_idx_d  = '0;
          steps_d    = '0;
          finished_d = 1'b0;
          success_d  = 1'b0;
          timeout_d  = 1'b0;
          fail_d     = 1'b0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          count_d    = '0;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = '0;
        clr_idx_d = clr_idx_q + LW'(1);
        if (clr_idx_q == LW'(NLocal - 1)) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (accept) begin
          steps_d = steps_q + 32'd1;
          case (in_op)
            OP_MOV: begin
              mem_we    = 1'b1;
              mem_wdata = op_a;
            end
            OP_ADD: begin
              mem_we    = 1'b1;
              mem_wdata = op_a + op_b;
            end
            OP_SUB: begin
              mem_we    = 1'b1;
              mem_wdata = op_a - op_b;
            end
            OP_OUT: ;
            OP_CHECK: begin
              if (op_a != op_b) fail_d = 1'b1;
            end
            OP_HALT: begin
              state_d    = S_DONE;
              finished_d = 1'b1;
              success_d  = !fail_q;
            end
            default: begin
              state_d    = S_DONE;
              finished_d = 1'b1;
              success_d  = 1'b0;
            end
          endcase
          // The limiting instruction still executes; only HALT escapes timeout.
          if (last_step && (in_op != OP_HALT)) begin
            state_d    = S_DONE;
            finished_d = 1'b1;
            timeout_d  = 1'b1;
            success_d  = 1'b0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= S_IDLE;
      clr_idx_q  <= '0;
      steps_q    <= '0;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
      timeout_q  <= 1'b0;
      fail_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      steps_q    <= steps_d;
      finished_q <= finished_d;
      success_q  <= success_d;
      timeout_q  <= timeout_d;
      fail_q     <= fail_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Local memory and FIFO storage writes.
  always_ff @(posedge clock) begin
    // NOTE: storage arrays are deliberately not reset; CLEAR zeroes local memory and out_valid masks stale FIFO words.
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    if (push)   fifo_q[wr_ptr_q] <= op_a;
  end

endmodule

// File: tb/tb_fpga_arith_runner.sv
// Self-checking bench for fpga_arith_runner: directed programs, a
// behavioural model compared every cycle, and hand-computed checkpoints.
module tb_fpga_arith_runner;

  localparam int W    = 12;
  localparam int NLOC = 8;
  localparam int NOUT = 4;
  localparam int MAXS = 16;

  localparam logic [2:0] MOV = 3'd0, ADD = 3'd1, SUB = 3'd2, OUTP = 3'd3,
                         CHK = 3'd4, HALT = 3'd5, ILL7 = 3'd7;

  logic          clock = 1'b0;
  logic          reset;
  logic          run = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [2:0]    in_target = '0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_a_local = 1'b0;
  logic          in_b_local = 1'b0;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;
  logic [2:0]    out_count;
  logic [31:0]   steps;
  logic          finished, success, timeout;

  fpga_arith_runner #(
    .MemoryElementWidth(W),
    .NLocal(NLOC),
    .NOut(NOUT),
    .MaxSteps(MAXS)
  ) dut (
    .clock(clock), .reset(reset), .run(run),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_target(in_target), .in_a(in_a), .in_b(in_b),
    .in_a_local(in_a_local), .in_b_local(in_b_local),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_count(out_count), .steps(steps), .finished(finished),
    .success(success), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_mem [NLOC];
  int  m_q[$];
  int  m_steps = 0;
  int  m_clr   = 0;
  bit  m_exec = 0, m_fin = 0, m_succ = 0, m_to = 0, m_fail = 0;
  int  m_a, m_b;
  bit  m_acc;
  bit  mon_en = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_steps = 0; m_clr = 0;
      m_exec = 0; m_fin = 0; m_succ = 0; m_to = 0; m_fail = 0;
    end else begin
      m_acc = m_exec && in_valid && (m_q.size() < NOUT);
      m_a   = in_a_local ? int'(m_mem[in_a[2:0]]) : int'(in_a);
      m_b   = in_b_local ? int'(m_mem[in_b[2:0]]) : int'(in_b);
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (run && !m_exec && m_clr == 0) begin
        m_q.delete();
        m_steps = 0; m_fin = 0; m_succ = 0; m_to = 0; m_fail = 0;
        m_clr = NLOC;
      end else if (m_clr > 0) begin
        m_mem[NLOC - m_clr] = '0;
        m_clr--;
        if (m_clr == 0) m_exec = 1;
      end else if (m_acc) begin
        m_steps++;
        case (in_op)
          MOV:  m_mem[in_target] = W'(m_a);
          ADD:  m_mem[in_target] = W'((m_a + m_b) % 4096);
          SUB:  m_mem[in_target] = W'((m_a - m_b + 4096) % 4096);
          OUTP: m_q.push_back(m_a);
          CHK:  if (m_a != m_b) m_fail = 1;
          HALT: begin m_exec = 0; m_fin = 1; m_succ = !m_fail; end
          default: begin m_exec = 0; m_fin = 1; m_succ = 0; end
        endcase
        if (m_steps == MAXS && in_op != HALT) begin
          m_exec = 0; m_fin = 1; m_succ = 0; m_to = 1;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      check("in_ready",  in_ready,  (m_exec && m_q.size() < NOUT));
      check("out_valid", out_valid, (m_q.size() > 0));
      check("out_count", out_count, m_q.size());
      check("out_data",  out_data,  (m_q.size() > 0) ? m_q[0] : 0);
      check("steps",     steps,     m_steps);
      check("finished",  finished,  m_fin);
      check("success",   success,   m_succ);
      check("timeout",   timeout,   m_to);
    end
  end

  // Pop recorder for the back-pressure test.
  bit rec_en = 0;
  int popped[$];
  always @(negedge clock) begin
    if (rec_en && out_valid && out_ready) popped.push_back(int'(out_data));
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic start_run(input string tag);
    int n = 0;
    run = 1'b1;
    @(posedge clock); #1 run = 1'b0;
    while (n < 20) begin
      @(negedge clock);
      if (in_ready) break;
      n++;
    end
    check({tag, "_clear_cycles"}, n, NLOC);
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [2:0] op, input int tgt, input int a, input bit al,
                      input int b, input bit bl);
    int n = 0;
    in_op = op; in_target = tgt[2:0];
    in_a = a[W-1:0]; in_a_local = al;
    in_b = b[W-1:0]; in_b_local = bl;
    in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clock);
    end
    check("send_accept", in_ready, 1);
    @(posedge clock); #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!finished && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("done_seen", finished, 1);
    @(posedge clock); #1;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clock); #1 out_ready = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (out_count != 0 && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", out_count, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_in_ready",  in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_steps",     steps, 0);
    check("rst_finished",  finished, 0);
    reset = 1'b0;
    mon_en = 1;
    @(posedge clock); #1;

    // 1: SUB 4-2, OUT, CHECK, HALT
    start_run("t1");
    send(SUB, 0, 4, 0, 2, 0);
    send(OUTP, 0, 0, 1, 0, 0);
    send(CHK, 0, 0, 1, 2, 0);
    send(HALT, 0, 0, 0, 0, 0);
    wait_done();
    check("t1_out_data", out_data, 2);
    check("t1_steps",    steps, 4);
    check("t1_success",  success, 1);
    check("t1_timeout",  timeout, 0);
    pop_one();

    // 2: wrap-around SUB and ADD
    start_run("t2");
    send(SUB, 1, 2, 0, 4, 0);
    send(OUTP, 0, 1, 1, 0, 0);
    send(ADD, 2, 4095, 0, 3, 0);
    send(OUTP, 0, 2, 1, 0, 0);
    send(HALT, 0, 0, 0, 0, 0);
    wait_done();
    check("t2_sub_wrap", out_data, 4094);
    pop_one();
    check("t2_add_wrap", out_data, 2);
    pop_one();

    // 3: back-pressure and simultaneous push/pop
    start_run("t3");
    for (int i = 1; i <= 4; i++) send(OUTP, 0, i, 0, 0, 0);
    @(negedge clock);
    check("t3_full_ready", in_ready, 0);
    check("t3_full_count", out_count, 4);
    @(posedge clock); #1;
    popped.delete();
    rec_en = 1;
    out_ready = 1'b1;
    send(OUTP, 0, 5, 0, 0, 0);
    drain();
    rec_en = 0;
    check("t3_pop_count", popped.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < popped.size()) check("t3_pop_order", popped[i], i + 1);
    send(OUTP, 0, 7, 0, 0, 0);
    send(OUTP, 0, 8, 0, 0, 0);
    check("t3_count2", out_count, 2);
    out_ready = 1'b1;
    send(OUTP, 0, 9, 0, 0, 0);
    out_ready = 1'b0;
    check("t3_pushpop_count", out_count, 2);
    check("t3_pushpop_head", out_data, 8);
    send(HALT, 0, 0, 0, 0, 0);
    wait_done();
    drain();

    // 4: failing CHECK, then illegal op
    start_run("t4a");
    send(CHK, 0, 5, 0, 6, 0);
    send(HALT, 0, 0, 0, 0, 0);
    wait_done();
    check("t4_chk_success", success, 0);
    start_run("t4b");
    send(MOV, 3, 77, 0, 0, 0);
    send(ILL7, 3, 99, 0, 0, 0);
    wait_done();
    check("t4_ill_success", success, 0);
    check("t4_ill_steps", steps, 2);
    check("t4_ill_no_write", dut.mem_q[3], 77);

    // 5: step-limit timeout (MaxSteps = 16)
    start_run("t5");
    for (int i = 0; i < MAXS; i++) send(MOV, i % 8, 100 + i, 0, 0, 0);
    wait_done();
    check("t5_timeout",  timeout, 1);
    check("t5_success",  success, 0);
    check("t5_steps",    steps, 16);
    check("t5_in_ready", in_ready, 0);
    check("t5_last_write", dut.mem_q[7], 115);

    // 6: reset mid-EXEC, then clean rerun
    start_run("t6a");
    send(OUTP, 0, 1, 0, 0, 0);
    send(OUTP, 0, 2, 0, 0, 0);
    check("t6_count_before", out_count, 2);
    reset = 1'b1;
    #1;
    check("t6_rst_in_ready",  in_ready, 0);
    check("t6_rst_out_valid", out_valid, 0);
    check("t6_rst_out_count", out_count, 0);
    check("t6_rst_out_data",  out_data, 0);
    check("t6_rst_steps",     steps, 0);
    check("t6_rst_finished",  finished, 0);
    check("t6_rst_success",   success, 0);
    check("t6_rst_timeout",   timeout, 0);
    @(posedge clock); @(posedge clock); #1 reset = 1'b0;
    @(posedge clock); #1;
    start_run("t6b");
    send(OUTP, 0, 5, 1, 0, 0);
    send(OUTP, 0, 7, 1, 0, 0);
    send(CHK, 0, 5, 1, 0, 0);
    send(HALT, 0, 0, 0, 0, 0);
    wait_done();
    check("t6_count", out_count, 2);
    check("t6_word0", out_data, 0);
    check("t6_success", success, 1);
    drain();

    @(posedge clock); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
